ble_packet_deframer: RTL and testbench
======================================

# ble_packet_deframer

Bit-level packet deframer for the BLE receive chain, directly downstream of the timing-recovery stage. On every `update_data` strobe it consumes one demodulated bit (the matched-filter decision taken at the recovered sample point), searches for the configured 32-bit access address within a programmable Hamming-distance tolerance, then assembles the PDU header, payload and CRC into bytes, optionally de-whitening them. It emits a byte stream with framing flags for the CRC checker and packet buffer.

## Interface
- `AA_BITS`, 32: access-address length in bits.
- `MAX_PDU_LEN`, 255: largest accepted header length field; larger values are clamped.
- `clk`  in  1  16 MHz system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `update_data`  in  1  one-cycle strobe from timing recovery; a bit is valid this cycle.
- `data_bit`  in  1  demodulated bit, sampled only when `update_data`=1.
- `search_en`  in  1  0 forces SEARCH and suppresses all outputs.
- `access_address`  in  32  expected AA, received LSB first.
- `aa_err_thresh`  in  3  maximum tolerated bit errors in the AA match (0–7).
- `channel_index`  in  6  BLE channel, seeds the de-whitening LFSR.
- `aa_match`  out  1  one-cycle pulse on AA detection.
- `byte_out`  out  8  assembled byte, LSB = first received bit.
- `byte_valid`  out  1  one-cycle pulse, `byte_out` valid.
- `is_header`  out  1  qualifies `byte_valid` for the two header bytes.
- `pdu_len`  out  8  length field captured from header byte 1; held until next AA match.
- `pkt_done`  out  1  one-cycle pulse coincident with `byte_valid` of the final CRC byte.

## Operation
- Reset: all outputs 0; state SEARCH; shift register, counters and LFSR cleared.
- Bits are acted on only in cycles with `update_data`=1; all other cycles hold state.
- SEARCH: 32-bit shift register, new bit into bit 31, shift right. Popcount of (register XOR `access_address`) ≤ `aa_err_thresh` and ≥32 bits received since entering SEARCH → pulse `aa_match`, load LFSR, clear byte/bit counters, go to HEADER.
- HEADER: collect 2 bytes (8 bits each, LSB first), both with `is_header`=1. Byte 1 loads `pdu_len` (clamped to `MAX_PDU_LEN`). Then go to PAYLOAD.
- PAYLOAD: collect `pdu_len` bytes, then 3 CRC bytes; total byte counter 9 bits. `pdu_len`=0 → straight to CRC bytes. Last CRC byte pulses `pkt_done`, return to SEARCH with the AA shift register cleared and the 32-bit fill counter restarted.
- De-whitening (when compiled in) applies to every bit after the AA, header through CRC. LFSR w[6:0] = {1'b1, channel_index} at AA match; per bit: out = bit ^ w[0]; w <= {w[0], w[6], w[5], w[4]^w[0], w[3], w[2], w[1]}.
- `search_en` deasserted in any state → SEARCH next cycle, no further output pulses; a partial packet is discarded without `pkt_done`.
- Asynchronous reset mid-packet aborts immediately; no flags emitted.
- `channel_index`, `access_address` and `aa_err_thresh` are sampled only at AA match or in SEARCH; changes mid-packet do not affect that packet.

## Timing
- All outputs registered. `aa_match`, `byte_valid`, `pkt_done` rise in the cycle after the `update_data` cycle carrying the completing bit; width one cycle.
- Minimum `update_data` spacing is 2 clocks; behaviour with back-to-back strobes is still correct (one bit per strobe).
- Packet with `pdu_len`=N yields N+5 `byte_valid` pulses after `aa_match`.
- The popcount compare is combinational from the shift register and must close at 16 MHz in one cycle.

## Configuration
- `BLE_DEWHITEN_EN` defined: LFSR de-whitening as above.
- Not defined: LFSR logic absent; bytes are raw received bits; `channel_index` unused.

## Structure
- Shared package/header: state encoding (SEARCH, HEADER, PAYLOAD), `AA_BITS`, CRC byte count (3), header byte count (2), LFSR seed bit position.
- One sub-module: `ble_dewhiten_lfsr` (load, step, output bit), instantiated only under `BLE_DEWHITEN_EN`.

## Test plan
- AA 0x8E89BED6, thresh 0, no dewhitening, header 0x00 0x02, payload 0xAA 0x55, CRC 0x11 0x22 0x33 → `aa_match`, 7 bytes in order, `is_header` on first 2, `pdu_len`=2, `pkt_done` on 0x33.
- Same AA with 2 bits flipped: thresh 1 → no match; thresh 2 → match.
- `BLE_DEWHITEN_EN`, channel 37, bits pre-whitened by a bench LFSR model → `byte_out` equals original plaintext.
- Header length 0 → exactly 5 bytes then `pkt_done`; length 0xFF with `MAX_PDU_LEN`=37 → `pdu_len`=37, 42 bytes.
- `search_en` dropped after payload byte 3 → no further `byte_valid`, no `pkt_done`; re-enable, next packet received cleanly.
- `rst` asserted mid-payload → all outputs 0 immediately; after release, AA needs a fresh 32 bits before any match.

Source files
------------

// File: rtl/ble_packet_deframer_pkg.sv
// rtl/ble_packet_deframer_pkg.sv - shared state encoding and framing constants for the BLE deframer
package ble_packet_deframer_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_e;

  localparam int AA_BITS_C     = 32;
  localparam int HDR_BYTES     = 2;
  localparam int CRC_BYTES     = 3;
  localparam int LFSR_W        = 7;
  localparam int LFSR_SEED_BIT = 6;

endpackage

// File: rtl/ble_dewhiten_lfsr.sv
// rtl/ble_dewhiten_lfsr.sv - 7-bit BLE whitening LFSR: seed load, per-bit step, XOR output
module ble_dewhiten_lfsr
  import ble_packet_deframer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [5:0] channel_i,
  input  logic       step_i,
  input  logic       in_bit_i,
  output logic       out_bit_o
);

  logic [LFSR_W-1:0] w_q;
  logic [LFSR_W-1:0] w_d;
  logic [LFSR_W-1:0] seed;

  always_comb begin
    seed                = {1'b0, channel_i};
    seed[LFSR_SEED_BIT] = 1'b1;
  end

  always_comb begin
    w_d = w_q;
    if (load_i) begin
      w_d = seed;
    end else if (step_i) begin
      w_d = {w_q[0], w_q[6], w_q[5], w_q[4] ^ w_q[0], w_q[3], w_q[2], w_q[1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_q <= '0;
    end else begin
      w_q <= w_d;
    end
  end

  assign out_bit_o = in_bit_i ^ w_q[0];

endmodule

// File: rtl/ble_packet_deframer.sv
// rtl/ble_packet_deframer.sv - BLE access-address search and byte deframer
// Optional de-whitening is compiled in with BLE_DEWHITEN_EN.
module ble_packet_deframer
  import ble_packet_deframer_pkg::*;
#(
  parameter int AA_BITS     = AA_BITS_C,
  parameter int MAX_PDU_LEN = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               update_data,
  input  logic               data_bit,
  input  logic               search_en,
  input  logic [AA_BITS-1:0] access_address,
  input  logic [2:0]         aa_err_thresh,
  input  logic [5:0]         channel_index,
  output logic               aa_match,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  output logic               is_header,
  output logic [7:0]         pdu_len,
  output logic               pkt_done
);

  localparam int                FILL_W    = $clog2(AA_BITS + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(AA_BITS);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(AA_BITS - 1);
  localparam logic [7:0]        MAX_LEN   = 8'(MAX_PDU_LEN);
  localparam logic [8:0]        TAIL_OFS  = 9'(HDR_BYTES + CRC_BYTES - 1);

  state_e             state_q, state_d;
  logic [AA_BITS-1:0] aa_sr_q, aa_sr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [8:0]         byte_cnt_q, byte_cnt_d;
  logic [7:0]         byte_sr_q, byte_sr_d;
  logic [7:0]         pdu_len_q, pdu_len_d;
  logic [7:0]         byte_out_q, byte_out_d;
  logic               aa_match_q, aa_match_d;
  logic               byte_valid_q, byte_valid_d;
  logic               is_header_q, is_header_d;
  logic               pkt_done_q, pkt_done_d;

  logic               bit_take;
  logic               rx_bit;
  logic [AA_BITS-1:0] aa_shift;
  logic [FILL_W-1:0]  aa_errs;
  logic               aa_hit;
  logic [7:0]         byte_next;
  logic               byte_done;
  logic               hdr_done;
  logic               last_byte;
  logic [7:0]         len_clamped;

  assign bit_take = update_data & search_en;
  assign aa_shift = {data_bit, aa_sr_q[AA_BITS-1:1]};

  // Popcount runs on the post-shift value so aa_match lands one cycle after the completing bit.
  always_comb begin
    aa_errs = '0;
    for (int i = 0; i < AA_BITS; i++) begin
      aa_errs = aa_errs + FILL_W'(aa_shift[i] ^ access_address[i]);
    end
  end

  assign aa_hit = (state_q == ST_SEARCH) && bit_take && (fill_q >= FILL_LAST) &&
                  (aa_errs <= FILL_W'(aa_err_thresh));

`ifdef BLE_DEWHITEN_EN
  ble_dewhiten_lfsr u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (aa_hit),
    .channel_i (channel_index),
    .step_i    (bit_take && (state_q != ST_SEARCH)),
    .in_bit_i  (data_bit),
    .out_bit_o (rx_bit)
  );
`else
  logic unused_channel;
  assign unused_channel = ^channel_index;
  assign rx_bit         = data_bit;
`endif

  assign byte_next   = {rx_bit, byte_sr_q[7:1]};
  assign byte_done   = bit_take && (state_q != ST_SEARCH) && (bit_cnt_q == 3'd7);
  assign hdr_done    = byte_done && (state_q == ST_HEADER) && (byte_cnt_q == 9'(HDR_BYTES - 1));
  assign last_byte   = byte_done && (state_q == ST_PAYLOAD) &&
                       (byte_cnt_q == ({1'b0, pdu_len_q} + TAIL_OFS));
  assign len_clamped = (byte_next > MAX_LEN) ? MAX_LEN : byte_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!search_en) begin
      state_d = ST_SEARCH;
    end else begin
      case (state_q)
        ST_SEARCH:  if (aa_hit)    state_d = ST_HEADER;
        ST_HEADER:  if (hdr_done)  state_d = ST_PAYLOAD;
        ST_PAYLOAD: if (last_byte) state_d = ST_SEARCH;
        default:                   state_d = ST_SEARCH;
      endcase
    end
  end

  always_comb begin
    aa_sr_d      = aa_sr_q;
    fill_d       = fill_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    byte_sr_d    = byte_sr_q;
    pdu_len_d    = pdu_len_q;
    byte_out_d   = byte_out_q;
    aa_match_d   = 1'b0;
    byte_valid_d = 1'b0;
    is_header_d  = 1'b0;
    pkt_done_d   = 1'b0;
    if (!search_en) begin
      aa_sr_d = '0;
      fill_d  = '0;
    end else if (bit_take) begin
      case (state_q)
        ST_SEARCH: begin
          aa_sr_d = aa_shift;
          fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
          if (aa_hit) begin
            aa_match_d = 1'b1;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
            pdu_len_d  = '0;
          end
        end
        ST_HEADER, ST_PAYLOAD: begin
          byte_sr_d = byte_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_done) begin
            byte_out_d   = byte_next;
            byte_valid_d = 1'b1;
            is_header_d  = (state_q == ST_HEADER);
            byte_cnt_d   = byte_cnt_q + 9'd1;
          end
          if (hdr_done) begin
            pdu_len_d = len_clamped;
          end
          if (last_byte) begin
            pkt_done_d = 1'b1;
            aa_sr_d    = '0;
            fill_d     = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aa_sr_q      <= '0;
      fill_q       <= '0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      byte_sr_q    <= '0;
      pdu_len_q    <= '0;
      byte_out_q   <= '0;
      aa_match_q   <= 1'b0;
      byte_valid_q <= 1'b0;
      is_header_q  <= 1'b0;
      pkt_done_q   <= 1'b0;
    end else begin
      aa_sr_q      <= aa_sr_d;
      fill_q       <= fill_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_sr_q    <= byte_sr_d;
      pdu_len_q    <= pdu_len_d;
      byte_out_q   <= byte_out_d;
      aa_match_q   <= aa_match_d;
      byte_valid_q <= byte_valid_d;
      is_header_q  <= is_header_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  assign aa_match   = aa_match_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign is_header  = is_header_q;
  assign pdu_len    = pdu_len_q;
  assign pkt_done   = pkt_done_q;

endmodule

// File: tb/tb_ble_packet_deframer.sv
// tb/tb_ble_packet_deframer.sv - directed table-driven bench for ble_packet_deframer
module tb_ble_packet_deframer;

  localparam int         MAXLEN = 37;
  localparam logic [31:0] AA    = 32'h8E89BED6;
`ifdef BLE_DEWHITEN_EN
  localparam bit WHITEN = 1'b1;
`else
  localparam bit WHITEN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        update_data;
  logic        data_bit;
  logic        search_en;
  logic [31:0] access_address;
  logic [2:0]  aa_err_thresh;
  logic [5:0]  channel_index;
  logic        aa_match;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        is_header;
  logic [7:0]  pdu_len;
  logic        pkt_done;

  ble_packet_deframer #(.AA_BITS(32), .MAX_PDU_LEN(MAXLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .update_data    (update_data),
    .data_bit       (data_bit),
    .search_en      (search_en),
    .access_address (access_address),
    .aa_err_thresh  (aa_err_thresh),
    .channel_index  (channel_index),
    .aa_match       (aa_match),
    .byte_out       (byte_out),
    .byte_valid     (byte_valid),
    .is_header      (is_header),
    .pdu_len        (pdu_len),
    .pkt_done       (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] rx_bytes[$];
  logic       rx_hdr[$];
  logic [7:0] exp_bytes[$];
  int         done_cnt;
  int         done_idx;
  int         match_cnt;

  always @(negedge clk) begin
    if (aa_match) match_cnt++;
    if (byte_valid) begin
      rx_bytes.push_back(byte_out);
      rx_hdr.push_back(is_header);
      if (pkt_done) done_idx = rx_bytes.size() - 1;
    end
    if (pkt_done) done_cnt++;
  end

  bit         whiten_on;
  logic [6:0] w;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    rx_bytes.delete();
    rx_hdr.delete();
    exp_bytes.delete();
    done_cnt  = 0;
    done_idx  = -1;
    match_cnt = 0;
  endtask

  task automatic restart();
    search_en = 1'b0;
    idle(2);
    search_en = 1'b1;
    idle(1);
  endtask

  // Transmitter-side whitening model, applied to every bit after the access address.
  task automatic send_bit(input logic b);
    logic tx;
    tx = b;
    if (WHITEN && whiten_on) begin
      tx = b ^ w[0];
      w  = {w[0], w[6], w[5], w[4] ^ w[0], w[3], w[2], w[1]};
    end
    @(negedge clk);
    update_data = 1'b1;
    data_bit    = tx;
    @(negedge clk);
    update_data = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    exp_bytes.push_back(v);
  endtask

  task automatic send_aa(input logic [31:0] aa);
    whiten_on = 1'b0;
    for (int i = 0; i < 32; i++) send_bit(aa[i]);
    whiten_on = 1'b1;
    w         = {1'b1, channel_index};
  endtask

  function automatic logic [7:0] pay_byte(input int i);
    if (i == 0) return 8'hAA;
    if (i == 1) return 8'h55;
    return 8'(i * 13 + 7);
  endfunction

  task automatic send_body(input logic [7:0] len_field, input int n_pay);
    send_byte(8'h00);
    send_byte(len_field);
    for (int i = 0; i < n_pay; i++) send_byte(pay_byte(i));
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
  endtask

  task automatic check_packet(input string tag, input int exp_len);
    int bad;
    int hbad;
    check({tag, " aa_match count"}, match_cnt, 1);
    check({tag, " byte count"}, rx_bytes.size(), exp_len + 5);
    bad  = 0;
    hbad = 0;
    for (int i = 0; i < rx_bytes.size() && i < exp_bytes.size(); i++) begin
      if (rx_bytes[i] !== exp_bytes[i]) bad++;
      if (rx_hdr[i] !== (i < 2)) hbad++;
    end
    check({tag, " wrong bytes"}, bad, 0);
    check({tag, " wrong is_header"}, hbad, 0);
    check({tag, " pkt_done count"}, done_cnt, 1);
    check({tag, " pkt_done index"}, done_idx, exp_len + 4);
    check({tag, " pdu_len"}, int'(pdu_len), exp_len);
  endtask

  typedef struct {
    logic [31:0] flip;
    logic [2:0]  thresh;
    logic [7:0]  len_field;
    bit          exp_match;
    int          exp_len;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h0000_0000, 3'd0, 8'h02, 1'b1, 2};
    vecs[1] = '{32'h0000_0101, 3'd1, 8'h02, 1'b0, 0};
    vecs[2] = '{32'h0000_0101, 3'd2, 8'h02, 1'b1, 2};
    vecs[3] = '{32'h0000_0000, 3'd0, 8'h00, 1'b1, 0};
    vecs[4] = '{32'h0000_0000, 3'd0, 8'hFF, 1'b1, MAXLEN};
    vecs[5] = '{32'h8421_0841, 3'd7, 8'h01, 1'b1, 1};
    vecs[6] = '{32'h8421_08C1, 3'd7, 8'h01, 1'b0, 0};

    rst            = 1'b0;
    update_data    = 1'b0;
    data_bit       = 1'b0;
    search_en      = 1'b0;
    access_address = AA;
    aa_err_thresh  = 3'd0;
    channel_index  = 6'd37;
    whiten_on      = 1'b0;
    w              = '0;
    clear_mon();

    #12;
    check("reset outputs", int'({aa_match, byte_valid, is_header, pkt_done, byte_out, pdu_len}), 0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    for (int v = 0; v < 7; v++) begin
      restart();
      clear_mon();
      aa_err_thresh = vecs[v].thresh;
      send_aa(AA ^ vecs[v].flip);
      if (vecs[v].exp_match) begin
        send_body(vecs[v].len_field, vecs[v].exp_len);
        idle(4);
        check_packet($sformatf("vec%0d", v), vecs[v].exp_len);
      end else begin
        idle(4);
        check($sformatf("vec%0d aa_match count", v), match_cnt, 0);
        check($sformatf("vec%0d byte count", v), rx_bytes.size(), 0);
      end
    end

    // search_en dropped after the third payload byte: rest of packet is discarded.
    restart();
    clear_mon();
    aa_err_thresh = 3'd0;
    send_aa(AA);
    send_byte(8'h00);
    send_byte(8'h05);
    for (int i = 0; i < 3; i++) send_byte(pay_byte(i));
    search_en = 1'b0;
    for (int i = 3; i < 5; i++) send_byte(pay_byte(i));
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    idle(4);
    check("drop byte count", rx_bytes.size(), 5);
    check("drop pkt_done count", done_cnt, 0);
    search_en = 1'b1;
    idle(2);
    clear_mon();
    send_aa(AA);
    send_body(8'h01, 1);
    idle(4);
    check_packet("after drop", 1);

    // Asynchronous reset in the middle of the payload.
    restart();
    clear_mon();
    send_aa(AA);
    send_byte(8'h00);
    send_byte(8'h04);
    send_byte(pay_byte(0));
    check("pre-reset pdu_len", int'(pdu_len), 4);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("mid reset outputs", int'({aa_match, byte_valid, is_header, pkt_done, byte_out, pdu_len}), 0);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    clear_mon();
    whiten_on = 1'b0;
    for (int i = 0; i < 31; i++) send_bit(AA[i]);
    idle(3);
    check("31 bits no match", match_cnt, 0);
    send_bit(AA[31]);
    idle(3);
    check("32nd bit match", match_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
